instr_loader: RTL and testbench

- Writer side of the instruction-memory interface that the CPU fetch path reads.
- Accepts a framed program image from a byte-stream source (UART receiver or testbench) and writes it into instruction memory through a synchronous write port.
- Holds the CPU in reset while loading, and releases it only after a verified image has been written.

---
 rtl/instr_loader_pkg.sv | 21 ++
 rtl/idle_timer.sv | 37 +++
 rtl/instr_loader.sv | 135 +++++++++++++
 tb/tb_instr_loader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding,
// frame length decoding and checksum width.
package instr_loader_pkg;

   typedef enum logic [2:0] {
      StWaitLen,
      StLoad,
      StCheck,
      StDone,
      StError
   } state_e;

   localparam int unsigned SumW = 8;
   localparam int unsigned LenW = 9;

   // A length byte of zero stands for a full 256-byte image.
   function automatic logic [LenW-1:0] frame_len(input logic [7:0] len_byte);
      return (len_byte == 8'd0) ? LenW'(256) : {1'b0, len_byte};
   endfunction

endpackage

// File: rtl/idle_timer.sv
// Idle-cycle watchdog: counts cycles without activity while running and flags
// the cycle on which the idle count would reach Limit.
module idle_timer #(
   parameter int unsigned Limit = 50000
) (
   input  logic clock,
   input  logic reset,
   input  logic run,
   input  logic kick,
   output logic expired
);

   localparam int unsigned CntW = (Limit < 2) ? 1 : $clog2(Limit + 1);

   logic [CntW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (!run || kick) begin
         count_d = '0;
      end else if (count_q != CntW'(Limit)) begin
         count_d = count_q + CntW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Fires on the idle cycle whose edge would make the count equal Limit.
   assign expired = run && !kick && (count_q == CntW'(Limit - 1));

endmodule

// File: rtl/instr_loader.sv
// Writes a framed, checksummed program image from a byte stream into
// instruction memory and holds the CPU in reset until a verified image is in.
module instr_loader
   import instr_loader_pkg::*;
#(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned START_ADDR = 0,
   parameter int unsigned TIMEOUT    = 50000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   input  logic              restart,
   output logic              w_en,
   output logic [ADDR_W-1:0] w_addr,
   output logic [7:0]        w_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

   localparam logic [ADDR_W-1:0] StartAddr = ADDR_W'(START_ADDR);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [SumW-1:0]   sum_q, sum_d;
   logic [LenW-1:0]   rem_q, rem_d;
   logic              w_en_q, w_en_d;
   logic [ADDR_W-1:0] w_addr_q, w_addr_d;
   logic [7:0]        w_data_q, w_data_d;

   logic accept;
   logic timer_run;
   logic timer_kick;
   logic timed_out;

   assign rx_ready   = (state_q == StWaitLen) || (state_q == StLoad) || (state_q == StCheck);
   assign accept     = rx_valid && rx_ready;
   assign timer_run  = (state_q == StLoad) || (state_q == StCheck);
   assign timer_kick = accept || restart;

   idle_timer #(
      .Limit(TIMEOUT)
   ) u_idle_timer (
      .clock  (clock),
      .reset  (reset),
      .run    (timer_run),
      .kick   (timer_kick),
      .expired(timed_out)
   );

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      sum_d    = sum_q;
      rem_d    = rem_q;
      w_en_d   = 1'b0;
      w_addr_d = w_addr_q;
      w_data_d = w_data_q;

      // Restart outranks any byte offered in the same cycle.
      if (restart) begin
         state_d = StWaitLen;
         addr_d  = StartAddr;
         sum_d   = '0;
         rem_d   = '0;
      end else begin
         unique case (state_q)
            StWaitLen: begin
               if (accept) begin
                  rem_d   = frame_len(rx_data);
                  addr_d  = StartAddr;
                  sum_d   = '0;
                  state_d = StLoad;
               end
            end
            StLoad: begin
               if (accept) begin
                  w_en_d   = 1'b1;
                  w_addr_d = addr_q;
                  w_data_d = rx_data;
                  sum_d    = sum_q + rx_data;
                  addr_d   = addr_q + ADDR_W'(1);
                  rem_d    = rem_q - LenW'(1);
                  if (rem_q == LenW'(1)) begin
                     state_d = StCheck;
                  end
               end else if (timed_out) begin
                  state_d = StError;
               end
            end
            StCheck: begin
               if (accept) begin
                  state_d = (rx_data == sum_q) ? StDone : StError;
               end else if (timed_out) begin
                  state_d = StError;
               end
            end
            StDone:  state_d = StDone;
            StError: state_d = StError;
            default: state_d = StError;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= StWaitLen;
         addr_q   <= StartAddr;
         sum_q    <= '0;
         rem_q    <= '0;
         w_en_q   <= 1'b0;
         w_addr_q <= '0;
         w_data_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         sum_q    <= sum_d;
         rem_q    <= rem_d;
         w_en_q   <= w_en_d;
         w_addr_q <= w_addr_d;
         w_data_q <= w_data_d;
      end
   end

   assign w_en     = w_en_q;
   assign w_addr   = w_addr_q;
   assign w_data   = w_data_q;
   assign done     = (state_q == StDone);
   assign error    = (state_q == StError);
   assign cpu_hold = (state_q != StDone);

endmodule

// File: tb/tb_instr_loader.sv
// Randomised scoreboard bench: two loaders with different start addresses see
// the same byte stream; a monitor matches every write against expected entries.
module tb_instr_loader;

   localparam int unsigned TimeoutCyc = 8;
   localparam logic [7:0]  StartA     = 8'h00;
   localparam logic [7:0]  StartB     = 8'h10;

   typedef struct {
      int         off;
      logic [7:0] data;
      int         cyc;
   } wr_t;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       restart = 1'b0;

   logic       rx_ready_a, w_en_a, cpu_hold_a, done_a, error_a;
   logic [7:0] w_addr_a, w_data_a;
   logic       rx_ready_b, w_en_b, cpu_hold_b, done_b, error_b;
   logic [7:0] w_addr_b, w_data_b;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   bit   started  = 1'b0;
   wr_t  q_a[$];
   wr_t  q_b[$];
   logic [7:0] frm[$];

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   instr_loader #(
      .ADDR_W(8), .START_ADDR(int'(StartA)), .TIMEOUT(TimeoutCyc)
   ) u_dut_a (
      .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready_a), .restart(restart), .w_en(w_en_a), .w_addr(w_addr_a),
      .w_data(w_data_a), .cpu_hold(cpu_hold_a), .done(done_a), .error(error_a)
   );

   instr_loader #(
      .ADDR_W(8), .START_ADDR(int'(StartB)), .TIMEOUT(TimeoutCyc)
   ) u_dut_b (
      .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready_b), .restart(restart), .w_en(w_en_b), .w_addr(w_addr_b),
      .w_data(w_data_b), .cpu_hold(cpu_hold_b), .done(done_b), .error(error_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cmp_write(input string name, input wr_t e, input logic [7:0] start,
                            input logic [7:0] addr, input logic [7:0] data);
      logic [7:0] exp_addr;
      exp_addr = start + 8'(e.off);
      check(name, {8'h0, addr, data, 8'(cyc)}, {8'h0, exp_addr, e.data, 8'(e.cyc)});
   endtask

   // Monitor: every write strobe must match the oldest expected write, one cycle
   // after the accept that produced it.
   always @(negedge clock) begin
      wr_t e;
      if (started) begin
         if (w_en_a === 1'b1) begin
            if (q_a.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_write_a: got addr %0h data %0h expected none",
                        w_addr_a, w_data_a);
            end else begin
               e = q_a.pop_front();
               cmp_write("write_a{addr,data,cyc}", e, StartA, w_addr_a, w_data_a);
            end
         end
         if (w_en_b === 1'b1) begin
            if (q_b.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_write_b: got addr %0h data %0h expected none",
                        w_addr_b, w_data_b);
            end else begin
               e = q_b.pop_front();
               cmp_write("write_b{addr,data,cyc}", e, StartB, w_addr_b, w_data_b);
            end
         end
      end
   end

   // Status vector {rx_ready, cpu_hold, done, error} for a given outcome.
   task automatic check_status(input string name, input bit exp_done, input bit exp_err);
      logic [3:0] exp;
      exp = {!exp_done && !exp_err, !exp_done, exp_done, exp_err};
      check({name, "_a{rdy,hold,done,err}"}, {28'h0, rx_ready_a, cpu_hold_a, done_a, error_a},
            {28'h0, exp});
      check({name, "_b{rdy,hold,done,err}"}, {28'h0, rx_ready_b, cpu_hold_b, done_b, error_b},
            {28'h0, exp});
   endtask

   function automatic logic [7:0] ref_sum();
      int s;
      s = 0;
      foreach (frm[i]) s = s + int'(frm[i]);
      return 8'(s % 256);
   endfunction

   task automatic send_byte(input logic [7:0] b, input int gap);
      @(negedge clock);
      repeat (gap) @(negedge clock);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clock);
      #1 rx_valid = 1'b0;
   endtask

   task automatic send_data(input logic [7:0] b, input int gap, input int off);
      wr_t e;
      send_byte(b, gap);
      e.off  = off;
      e.data = b;
      e.cyc  = cyc;
      q_a.push_back(e);
      q_b.push_back(e);
   endtask

   // Sends length, the first n_send entries of frm, and optionally the checksum.
   task automatic send_frame(input logic [7:0] len_byte, input int n_send, input int max_gap,
                             input bit send_chk, input logic [7:0] chk);
      send_byte(len_byte, $urandom_range(0, 2));
      for (int i = 0; i < n_send; i++) send_data(frm[i], $urandom_range(0, max_gap), i);
      if (send_chk) send_byte(chk, $urandom_range(0, max_gap));
   endtask

   task automatic pulse_restart(input bit with_byte, input logic [7:0] b);
      @(negedge clock);
      restart  = 1'b1;
      rx_valid = with_byte;
      rx_data  = b;
      @(posedge clock);
      #1;
      restart  = 1'b0;
      rx_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_a{wen,waddr,wdata}"}, {15'h0, w_en_a, w_addr_a, w_data_a}, 32'h0);
      check({name, "_b{wen,waddr,wdata}"}, {15'h0, w_en_b, w_addr_b, w_data_b}, 32'h0);
      check_status(name, 1'b0, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test expected finish within bound");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] chk;
      int         k0;
      bit         good;
      int         len;

      repeat (2) @(posedge clock);
      @(negedge clock);
      check_reset_outputs("reset_state");
      reset   = 1'b1;
      started = 1'b1;

      // Nominal three-byte image.
      frm = '{8'hA1, 8'hB2, 8'hC3};
      send_frame(8'h03, 3, 0, 1'b1, ref_sum());
      @(negedge clock);
      check_status("nominal", 1'b1, 1'b0);
      // A byte offered while done is not taken and causes no write.
      send_byte(8'h55, 0);
      @(negedge clock);
      check_status("done_ignores_bytes", 1'b1, 1'b0);
      pulse_restart(1'b0, 8'h00);
      @(negedge clock);
      check_status("restart_from_done", 1'b0, 1'b0);

      // Bad checksum.
      frm = '{8'h10, 8'h20};
      send_frame(8'h02, 2, 1, 1'b1, 8'h31);
      @(negedge clock);
      check_status("bad_checksum", 1'b0, 1'b1);
      pulse_restart(1'b0, 8'h00);
      @(negedge clock);
      check_status("restart_from_error", 1'b0, 1'b0);

      // Full 256-byte image with address wrap.
      frm = {};
      for (int i = 0; i < 256; i++) frm.push_back(8'(i));
      chk = ref_sum();
      check("wrap_ref_checksum", {24'h0, chk}, 32'h80);
      send_frame(8'h00, 256, 0, 1'b1, chk);
      @(negedge clock);
      check_status("wrap_256", 1'b1, 1'b0);
      pulse_restart(1'b0, 8'h00);

      // Timeout: one data byte then silence.
      frm = '{8'h55};
      send_frame(8'h02, 1, 0, 1'b0, 8'h00);
      k0 = cyc;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (error_a === 1'b1) break;
      end
      check("timeout_latency", 32'(cyc - k0), 32'(TimeoutCyc));
      check_status("timeout", 1'b0, 1'b1);
      pulse_restart(1'b0, 8'h00);

      // Reset in the middle of a frame.
      frm = '{8'h01, 8'h02, 8'h03, 8'h04};
      send_frame(8'h04, 2, 1, 1'b0, 8'h00);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      @(negedge clock);
      check_reset_outputs("mid_frame_reset");
      reset = 1'b1;
      frm = '{8'h7E};
      send_frame(8'h01, 1, 0, 1'b1, 8'h7E);
      @(negedge clock);
      check_status("after_reset_load", 1'b1, 1'b0);
      pulse_restart(1'b0, 8'h00);

      // Restart together with a data byte: that byte is dropped.
      frm = '{8'h11, 8'h22, 8'h33, 8'h44};
      send_frame(8'h04, 2, 0, 1'b0, 8'h00);
      pulse_restart(1'b1, 8'h33);
      @(negedge clock);
      check_status("restart_with_byte", 1'b0, 1'b0);

      // Random frames, gaps up to one below the timeout.
      for (int f = 0; f < 6; f++) begin
         len = $urandom_range(1, 40);
         frm = {};
         for (int i = 0; i < len; i++) frm.push_back(8'($urandom_range(0, 255)));
         good = ($urandom_range(0, 3) != 0);
         chk  = good ? ref_sum() : (ref_sum() ^ 8'($urandom_range(1, 255)));
         send_frame(8'(len), len, int'(TimeoutCyc) - 1, 1'b1, chk);
         @(negedge clock);
         check_status("random_frame", good, !good);
         pulse_restart(1'b0, 8'h00);
      end

      repeat (3) @(negedge clock);
      check("pending_writes_a", 32'(q_a.size()), 32'h0);
      check("pending_writes_b", 32'(q_b.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
